// File: rtl/clock_pkg.sv
// Shared types, digit limits and field validation for the BCD time-of-day counter.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX         = 4'd5;
  localparam bcd_t MIN_TENS_MAX         = 4'd5;
  localparam bcd_t UNITS_MAX            = 4'd9;
  localparam bcd_t HOUR_TENS_MAX        = 4'd2;
  localparam bcd_t HOUR_UNITS_MAX_AT_20 = 4'd3;

  // One hh or mm field: tens within range, units a BCD digit, and units capped when
  // tens sits at its maximum (e.g. 2x hours stop at 23).
  function automatic logic bcd_time_valid(input bcd_t tens, input bcd_t units,
                                          input bcd_t tens_max, input bcd_t units_max_at_top);
    return (tens <= tens_max) && (units <= UNITS_MAX) &&
           !((tens == tens_max) && (units > units_max_at_top));
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// Single BCD digit counter, mod (max+1), with synchronous load taking priority over inc.
module bcd_digit_cnt
  import clock_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic [3:0] max,
  output logic [3:0] q,
  output logic       carry
);

  bcd_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (inc) begin
      q_d = (q_q == max) ? 4'd0 : q_q + 4'd1;
    end
  end

  assign carry = inc && (q_q == max);
  assign q     = q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// 24-hour BCD hh:mm:ss counter with 1 Hz prescaler and synchronised set mode.
// Optional alarm comparator enabled by defining TIME_KEEPER_ALARM_MATCH_EN.
module time_keeper
  import clock_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 50_000_000,
  parameter int unsigned SYNC_STAGES = 2
`ifdef TIME_KEEPER_ALARM_MATCH_EN
  ,
  parameter int unsigned RING_SEC    = 60
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_mode,
  input  logic [3:0] set_h1,
  input  logic [3:0] set_h0,
  input  logic [3:0] set_m1,
  input  logic [3:0] set_m0,
`ifdef TIME_KEEPER_ALARM_MATCH_EN
  input  logic [3:0] al_h1,
  input  logic [3:0] al_h0,
  input  logic [3:0] al_m1,
  input  logic [3:0] al_m0,
  input  logic       al_enable,
  output logic       alarm_ring,
`endif
  output logic [3:0] h1,
  output logic [3:0] h0,
  output logic [3:0] m1,
  output logic [3:0] m0,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic       sec_tick,
  output logic       min_roll
);

  localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic                   sec_tick_q, sec_tick_d;
  logic                   min_roll_q, min_roll_d;
  logic                   set_s, inc;
  logic                   hour_ok, min_ok;
  bcd_t                   h0_max;
  logic                   c_s0, c_s1, c_m0, c_m1, c_h0, c_h1;
  logic                   unused_h1_carry;

  assign set_s = sync_q[SYNC_STAGES-1];
  // Set mode takes priority: no increment in any cycle where set_s is high.
  assign inc   = !set_s && (presc_q == PRESC_LAST);

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], set_mode};
    presc_d    = presc_q + PW'(1);
    if (set_s || (presc_q == PRESC_LAST)) begin
      presc_d = '0;
    end
    sec_tick_d = inc;
    min_roll_d = c_s1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      presc_q    <= '0;
      sec_tick_q <= 1'b0;
      min_roll_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      presc_q    <= presc_d;
      sec_tick_q <= sec_tick_d;
      min_roll_q <= min_roll_d;
    end
  end

  assign sec_tick = sec_tick_q;
  assign min_roll = min_roll_q;

  assign hour_ok = bcd_time_valid(set_h1, set_h0, HOUR_TENS_MAX, HOUR_UNITS_MAX_AT_20);
  assign min_ok  = bcd_time_valid(set_m1, set_m0, MIN_TENS_MAX, UNITS_MAX);
  assign h0_max  = (h1 == HOUR_TENS_MAX) ? HOUR_UNITS_MAX_AT_20 : UNITS_MAX;

  bcd_digit_cnt u_s0 (
    .clk(clk), .reset(reset), .inc(inc), .load(set_s), .load_val(4'd0),
    .max(UNITS_MAX), .q(s0), .carry(c_s0)
  );
  bcd_digit_cnt u_s1 (
    .clk(clk), .reset(reset), .inc(c_s0), .load(set_s), .load_val(4'd0),
    .max(SEC_TENS_MAX), .q(s1), .carry(c_s1)
  );
  bcd_digit_cnt u_m0 (
    .clk(clk), .reset(reset), .inc(c_s1), .load(set_s), .load_val(min_ok ? set_m0 : 4'd0),
    .max(UNITS_MAX), .q(m0), .carry(c_m0)
  );
  bcd_digit_cnt u_m1 (
    .clk(clk), .reset(reset), .inc(c_m0), .load(set_s), .load_val(min_ok ? set_m1 : 4'd0),
    .max(MIN_TENS_MAX), .q(m1), .carry(c_m1)
  );
  bcd_digit_cnt u_h0 (
    .clk(clk), .reset(reset), .inc(c_m1), .load(set_s), .load_val(hour_ok ? set_h0 : 4'd0),
    .max(h0_max), .q(h0), .carry(c_h0)
  );
  bcd_digit_cnt u_h1 (
    .clk(clk), .reset(reset), .inc(c_h0), .load(set_s), .load_val(hour_ok ? set_h1 : 4'd0),
    .max(HOUR_TENS_MAX), .q(h1), .carry(c_h1)
  );

  assign unused_h1_carry = c_h1;

`ifdef TIME_KEEPER_ALARM_MATCH_EN
  localparam int unsigned RW = (RING_SEC > 1) ? $clog2(RING_SEC + 1) : 1;

  logic          ring_q, ring_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic          al_match;
  bcd_t          nm0, nm1, nh0, nh1;

  always_comb begin
    // hh:mm after the minute rollover; only meaningful when c_s1 is high.
    nm0      = c_m0 ? 4'd0 : m0 + 4'd1;
    nm1      = c_m0 ? (c_m1 ? 4'd0 : m1 + 4'd1) : m1;
    nh0      = c_m1 ? (c_h0 ? 4'd0 : h0 + 4'd1) : h0;
    nh1      = c_h0 ? (c_h1 ? 4'd0 : h1 + 4'd1) : h1;
    al_match = c_s1 && ({nh1, nh0, nm1, nm0} == {al_h1, al_h0, al_m1, al_m0});

    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;
    if (!al_enable || set_s) begin
      ring_d     = 1'b0;
      ring_cnt_d = '0;
    end else if (al_match) begin
      ring_d     = 1'b1;
      ring_cnt_d = RW'(RING_SEC);
    end else if (inc && ring_q) begin
      if (ring_cnt_q <= RW'(1)) begin
        ring_d     = 1'b0;
        ring_cnt_d = '0;
      end else begin
        ring_cnt_d = ring_cnt_q - RW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ring_q     <= 1'b0;
      ring_cnt_q <= '0;
    end else begin
      ring_q     <= ring_d;
      ring_cnt_q <= ring_cnt_d;
    end
  end

  assign alarm_ring = ring_q;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: a time model pushes expected digits per tick to a queue,
// popped and compared when the DUT raises sec_tick.
module tb_time_keeper;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned SYNC    = 2;

  logic       clk = 1'b0;
  logic       reset, set_mode;
  logic [3:0] set_h1, set_h0, set_m1, set_m0;
  logic [3:0] h1, h0, m1, m0, s1, s0;
  logic       sec_tick, min_roll;
  logic [23:0] dut_t;
`ifdef TIME_KEEPER_ALARM_MATCH_EN
  logic [3:0] al_h1, al_h0, al_m1, al_m0;
  logic       al_enable, alarm_ring;
`endif

  assign dut_t = {h1, h0, m1, m0, s1, s0};

  time_keeper #(
    .CLK_DIV(CLK_DIV),
    .SYNC_STAGES(SYNC)
`ifdef TIME_KEEPER_ALARM_MATCH_EN
    , .RING_SEC(3)
`endif
  ) dut (
    .clk(clk), .reset(reset), .set_mode(set_mode),
    .set_h1(set_h1), .set_h0(set_h0), .set_m1(set_m1), .set_m0(set_m0),
`ifdef TIME_KEEPER_ALARM_MATCH_EN
    .al_h1(al_h1), .al_h0(al_h0), .al_m1(al_m1), .al_m0(al_m0),
    .al_enable(al_enable), .alarm_ring(alarm_ring),
`endif
    .h1(h1), .h0(h0), .m1(m1), .m0(m0), .s1(s1), .s0(s0),
    .sec_tick(sec_tick), .min_roll(min_roll)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] t;
    logic        roll;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mh = 0, mm = 0, ms = 0;

  function automatic logic [23:0] enc(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic advance_model();
    exp_t e;
    e.roll = 1'b0;
    ms++;
    if (ms == 60) begin
      ms = 0;
      e.roll = 1'b1;
      mm++;
      if (mm == 60) begin
        mm = 0;
        mh++;
        if (mh == 24) mh = 0;
      end
    end
    e.t = enc(mh, mm, ms);
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for the next sec_tick and checks spacing, digits and min_roll.
  task automatic tick(input string tag, input int exp_cyc);
    int   cyc;
    exp_t e;
    advance_model();
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (sec_tick !== 1'b1 && cyc < int'(CLK_DIV + SYNC + 8));
    chk({tag, "_period"}, cyc, exp_cyc);
    e = exp_q.pop_front();
    chk({tag, "_time"}, {8'd0, dut_t}, {8'd0, e.t});
    chk({tag, "_roll"}, {31'd0, min_roll}, {31'd0, e.roll});
  endtask

  task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    set_h1 = a; set_h0 = b; set_m1 = c; set_m0 = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    set_mode = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
`ifdef TIME_KEEPER_ALARM_MATCH_EN
    {al_h1, al_h0, al_m1, al_m0} = 16'h0001;
    al_enable = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_time", {8'd0, dut_t}, 32'd0);
    chk("rst_tick", {31'd0, sec_tick}, 32'd0);
    chk("rst_roll", {31'd0, min_roll}, 32'd0);

    reset = 1'b0;
    for (int i = 0; i < 60; i++) tick("run", CLK_DIV);
    chk("run_one_min", {8'd0, dut_t}, {8'd0, enc(0, 1, 0)});

    // Set mode: continuous reload with per-field validation.
    set_digits(4'd2, 4'd3, 4'd5, 4'd9);
    set_mode = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    chk("set_2359", {8'd0, dut_t}, {8'd0, enc(23, 59, 0)});
    chk("set_no_tick", {31'd0, sec_tick}, 32'd0);
    set_digits(4'd2, 4'd5, 4'd6, 4'd1);
    @(negedge clk);
    chk("set_2561", {8'd0, dut_t}, {8'd0, enc(0, 0, 0)});
    set_digits(4'd1, 4'd9, 4'd6, 4'd1);
    @(negedge clk);
    chk("set_1961", {8'd0, dut_t}, {8'd0, enc(19, 0, 0)});
    set_digits(4'd2, 4'd4, 4'd3, 4'd0);
    @(negedge clk);
    chk("set_2430", {8'd0, dut_t}, {8'd0, enc(0, 30, 0)});
    set_digits(4'd2, 4'd3, 4'd5, 4'd9);
    @(negedge clk);
    chk("set_2359b", {8'd0, dut_t}, {8'd0, enc(23, 59, 0)});

    mh = 23; mm = 59; ms = 0;
    set_mode = 1'b0;
    tick("resume", CLK_DIV + SYNC);
    for (int i = 0; i < 58; i++) tick("run_2359", CLK_DIV);
    chk("at_235959", {8'd0, dut_t}, {8'd0, enc(23, 59, 59)});
    tick("day_wrap", CLK_DIV);

    // Synchronised set_mode rises exactly in the increment cycle.
    @(negedge clk);
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    set_mode = 1'b1;
    for (int i = 0; i < int'(SYNC + 1); i++) begin
      @(negedge clk);
      chk("race_no_tick", {31'd0, sec_tick}, 32'd0);
    end
    chk("race_load", {8'd0, dut_t}, {8'd0, enc(12, 34, 0)});

    mh = 12; mm = 34; ms = 0;
    set_mode = 1'b0;
    tick("resume2", CLK_DIV + SYNC);
    for (int i = 0; i < 55; i++) tick("run_1234", CLK_DIV);
    chk("at_123456", {8'd0, dut_t}, {8'd0, enc(12, 34, 56)});

    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_time", {8'd0, dut_t}, 32'd0);
    chk("async_rst_tick", {31'd0, sec_tick}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mh = 0; mm = 0; ms = 0;
    tick("post_reset", CLK_DIV);

`ifdef TIME_KEEPER_ALARM_MATCH_EN
    al_enable = 1'b1;
    for (int i = 0; i < 58; i++) tick("al_lead", CLK_DIV);
    chk("al_idle", {31'd0, alarm_ring}, 32'd0);
    tick("al_match", CLK_DIV);
    chk("al_rise", {31'd0, alarm_ring}, 32'd1);
    tick("al_r1", CLK_DIV);
    chk("al_hold1", {31'd0, alarm_ring}, 32'd1);
    tick("al_r2", CLK_DIV);
    chk("al_hold2", {31'd0, alarm_ring}, 32'd1);
    tick("al_r3", CLK_DIV);
    chk("al_fall", {31'd0, alarm_ring}, 32'd0);

    {al_h1, al_h0, al_m1, al_m0} = 16'h0002;
    for (int i = 0; i < 57; i++) tick("al_lead2", CLK_DIV);
    chk("al2_rise", {31'd0, alarm_ring}, 32'd1);
    @(negedge clk);
    al_enable = 1'b0;
    @(negedge clk);
    chk("al2_disable", {31'd0, alarm_ring}, 32'd0);
`endif

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
